cache_assoc: RTL and testbench
==============================

# cache_assoc

Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement. It sits between the pipeline memory stage and the 128-bit block memory. It is the successor to the fixed 2-way, 4-set cache: set count and associativity are configurable, hits complete with no stall cycle, and victims are chosen by invalid-first then LRU.

## Interface
- SETS, 4, number of sets; power of two, 2..64; IDX = log2(SETS).
- WAYS, 2, associativity; 1, 2, 4 or 8; AW = max(1, log2(WAYS)).
- Derived: TAGLEN = 28 - IDX; 4 words (128 bits) per line.
- clk  input  1  single clock, rising edge.
- proc_reset_n  input  1  reset; asynchronous assert, active-low.
- proc_read / proc_write  input  1 each  request strobes; held until proc_stall is low.
- proc_addr  input  30  word address; [1:0] word offset, [IDX+1:2] index, [29:IDX+2] tag.
- proc_wdata  input  32  store data.
- proc_rdata  output  32  load data; combinational, valid in the hit cycle, otherwise 0.
- proc_stall  output  1  combinational stall.
- mem_read / mem_write  output  1 each  registered block request.
- mem_addr  output  28  registered block address.
- mem_wdata  output  128  registered victim line.
- mem_rdata  input  128  refill line, valid with mem_ready.
- mem_ready  input  1  memory completion, one cycle.

## Operation
- Per set and way: data[128], tag[TAGLEN], valid, dirty, age[AW]. Age 0 is MRU and WAYS-1 is LRU; the ages in a set always form a permutation.
- States are COMPARE (idle/lookup), WRITEBACK and ALLOCATE.
- **COMPARE**
  - With no request: proc_stall=0 and nothing changes.
  - Hit (valid && tag match in exactly one way):
    - proc_stall=0.
    - Read: proc_rdata = the offset word.
    - Write: the offset word is replaced by proc_wdata and dirty is set on the next edge.
    - LRU update: the hit way's age becomes 0; every way with age below the hit way's old age increments.
  - Miss: proc_stall=1.
    - Victim = lowest-index invalid way; if none, the way with age WAYS-1.
    - Victim dirty → WRITEBACK, otherwise → ALLOCATE.
    - The victim way is latched for the miss.
- **WRITEBACK**
  - mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line.
  - Outputs are held until mem_ready=1.
  - Then go to ALLOCATE and clear dirty.
- **ALLOCATE**
  - mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready=1: line=mem_rdata, tag written, valid=1, dirty=0; go to COMPARE.
  - The original request then hits (write-allocate) and performs the LRU update.
- proc_read and proc_write both high is illegal. The block treats it as a read and performs no write.
- Requests are assumed stable while stalled. Changing proc_addr mid-miss is undefined but must not deadlock the FSM.

## Timing
- Reset (async, proc_reset_n=0):
  - State = COMPARE.
  - All valid and dirty bits = 0.
  - Way w age = w.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - proc_stall and proc_rdata follow from the cleared state: both 0 with no request.
  - Data and tag arrays need not be reset.
- Reset mid-miss: mem strobes drop immediately and dirty data is discarded.
- Hit: zero stall cycles. The write takes effect at the edge ending the hit cycle.
- mem strobes:
  - Rise on the first cycle in WRITEBACK/ALLOCATE, registered from the state transition.
  - Fall the cycle after mem_ready is sampled high.
  - mem_read and mem_write are never both high.
- Clean miss with mem_ready in cycle k (counting the miss cycle as 0): stall is high for cycles 0..k; the hit completes in cycle k+1.
- Dirty miss: the writeback latency adds to that.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.

## Structure
- Package cache_pkg holds:
  - the state enum (COMPARE, WRITEBACK, ALLOCATE);
  - address-slice functions (index, tag, offset);
  - TAGLEN/AW derivation functions.
- Sub-module cache_lru, parametrised by WAYS:
  - combinational next-age computation for one set (hit-way input → new age vector);
  - LRU-way output.
- The top level holds the arrays, the FSM and the registered mem outputs.

## Test plan
- **Reset, then cold read miss.** SETS=4, WAYS=2; read 0x10 with mem_ready 3 cycles later, mem_rdata word0=0xAAAA0000.
  - Expect mem_read with mem_addr=0x4.
  - Then a hit with proc_rdata=0xAAAA0000.
  - proc_stall high for exactly 4 cycles.
- **Write hit.** Write 0xDEADBEEF to 0x11, then read 0x11.
  - Expect 0 stall cycles on both and rdata 0xDEADBEEF.
  - No mem traffic.
- **LRU, no writeback.** Read miss 0x00, 0x10 and 0x20 (same set 0, 2-way), then read 0x00 again.
  - The 0x20 fill evicts 0x00 (LRU).
  - The final read misses and evicts 0x10, not 0x20.
- **Dirty eviction.** Write 0x12345678 to 0x00, then miss 0x10 and 0x20 in set 0.
  - Expect mem_write, mem_addr=0x0, mem_wdata[31:0]=0x12345678.
  - Then mem_read with mem_addr=0x8.
- **Async reset mid-ALLOCATE.** Pulse proc_reset_n low between edges.
  - mem_read drops immediately.
  - The subsequent read of the same address misses.
- **Configuration sweep.** SETS=64, WAYS=4, 200 random reads/writes against a reference model with random mem_ready latency 1-5.
  - All rdata matches.
  - Age vectors stay permutations.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the set-associative data cache.
//   - state_e   : controller states
//   - aw_of / idx_of_sets / taglen_of : derived field widths
//   - addr_off / addr_idx / addr_tag  : word-address slicing
package cache_pkg;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned BLK_W  = 28;
   localparam int unsigned LINE_W = 128;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      COMPARE   = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   // Age/way-select width; a direct-mapped cache still keeps a 1-bit field.
   function automatic int unsigned aw_of(input int unsigned ways);
      return (ways <= 1) ? 1 : $clog2(ways);
   endfunction

   function automatic int unsigned idx_of_sets(input int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned taglen_of(input int unsigned sets);
      return BLK_W - $clog2(sets);
   endfunction

   function automatic logic [1:0] addr_off(input logic [ADDR_W-1:0] a);
      return a[1:0];
   endfunction

   // Index is at most 6 bits (64 sets); the caller narrows to its own width.
   function automatic logic [5:0] addr_idx(input logic [ADDR_W-1:0] a, input int unsigned idx);
      return 6'((a >> 2) & ((30'd1 << idx) - 30'd1));
   endfunction

   function automatic logic [BLK_W-1:0] addr_tag(input logic [ADDR_W-1:0] a, input int unsigned idx);
      return BLK_W'(a >> (idx + 2));
   endfunction

endpackage

// File: rtl/cache_lru.sv
// cache_lru: true-LRU age update for one set.
//   age_i     : current age per way (0 = MRU, WAYS-1 = LRU)
//   hit_way_i : way being touched
//   age_o     : ages after touching hit_way_i
//   lru_way_o : way currently holding age WAYS-1
module cache_lru
   import cache_pkg::*;
#(
   parameter  int unsigned WAYS = 2,
   localparam int unsigned AW   = aw_of(WAYS)
) (
   input  logic [WAYS-1:0][AW-1:0] age_i,
   input  logic [AW-1:0]           hit_way_i,
   output logic [WAYS-1:0][AW-1:0] age_o,
   output logic [AW-1:0]           lru_way_o
);

   // Touched way goes to 0; ways younger than it age by one, older ones keep their age.
   always_comb begin
      age_o     = age_i;
      lru_way_o = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (AW'(w) == hit_way_i) begin
            age_o[w] = '0;
         end else if (age_i[w] < age_i[hit_way_i]) begin
            age_o[w] = age_i[w] + AW'(1);
         end
         if (age_i[w] == AW'(WAYS - 1)) begin
            lru_way_o = AW'(w);
         end
      end
   end

endmodule

// File: rtl/cache_assoc.sv
// cache_assoc: N-way set-associative write-back / write-allocate data cache.
//   proc_*  : pipeline side; hits complete combinationally, misses raise proc_stall
//   mem_*   : 128-bit block memory side; requests registered, mem_ready is a 1-cycle completion
module cache_assoc
   import cache_pkg::*;
#(
   parameter int unsigned SETS = 4,
   parameter int unsigned WAYS = 2
) (
   input  logic                clk,
   input  logic                proc_reset_n,
   input  logic                proc_read,
   input  logic                proc_write,
   input  logic [ADDR_W-1:0]   proc_addr,
   input  logic [WORD_W-1:0]   proc_wdata,
   output logic [WORD_W-1:0]   proc_rdata,
   output logic                proc_stall,
   output logic                mem_read,
   output logic                mem_write,
   output logic [BLK_W-1:0]    mem_addr,
   output logic [LINE_W-1:0]   mem_wdata,
   input  logic [LINE_W-1:0]   mem_rdata,
   input  logic                mem_ready
);

   localparam int unsigned IDX    = idx_of_sets(SETS);
   localparam int unsigned AW     = aw_of(WAYS);
   localparam int unsigned TAGLEN = taglen_of(SETS);

   typedef logic [WAYS-1:0][AW-1:0] age_vec_t;

   state_e              state_q, state_d;
   logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [BLK_W-1:0]    mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [AW-1:0]       victim_q, victim_d;
   logic [IDX-1:0]      midx_q, midx_d;

   logic [LINE_W-1:0]   data_q  [SETS][WAYS];
   logic [TAGLEN-1:0]   tag_q   [SETS][WAYS];
   logic [WAYS-1:0]     valid_q [SETS];
   logic [WAYS-1:0]     dirty_q [SETS];
   age_vec_t            age_q   [SETS];

   logic [IDX-1:0]      idx;
   logic [TAGLEN-1:0]   tag;
   logic [1:0]          off;
   logic                req, is_wr, hit;
   logic [WAYS-1:0]     hit_vec;
   logic [AW-1:0]       hit_way, victim, lru_way;
   age_vec_t            age_nxt;
   logic                hit_upd, wb_done, fill;

   assign idx   = IDX'(addr_idx(proc_addr, IDX));
   assign tag   = TAGLEN'(addr_tag(proc_addr, IDX));
   assign off   = addr_off(proc_addr);
   assign req   = proc_read | proc_write;
   // Read and write together is treated as a plain read.
   assign is_wr = proc_write & ~proc_read;

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   cache_lru #(.WAYS(WAYS)) u_lru (
      .age_i     (age_q[idx]),
      .hit_way_i (hit_way),
      .age_o     (age_nxt),
      .lru_way_o (lru_way)
   );

   // Tag lookup and victim choice: lowest invalid way first, otherwise LRU.
   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
         if (hit_vec[w]) hit_way = AW'(w);
      end
      hit    = |hit_vec;
      victim = lru_way;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) victim = AW'(w);
      end
   end

   // Next-state and registered mem request computation.
   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      victim_d    = victim_q;
      midx_d      = midx_q;
      proc_stall  = 1'b0;
      proc_rdata  = '0;
      hit_upd     = 1'b0;
      wb_done     = 1'b0;
      fill        = 1'b0;
      unique case (state_q)
         COMPARE: begin
            if (req) begin
               if (hit) begin
                  hit_upd = 1'b1;
                  if (!is_wr) proc_rdata = data_q[idx][hit_way][{off, 5'd0} +: WORD_W];
               end else begin
                  proc_stall = 1'b1;
                  victim_d   = victim;
                  midx_d     = idx;
                  if (dirty_q[idx][victim]) begin
                     state_d     = WRITEBACK;
                     mem_write_d = 1'b1;
                     mem_addr_d  = {tag_q[idx][victim], idx};
                     mem_wdata_d = data_q[idx][victim];
                  end else begin
                     state_d    = ALLOCATE;
                     mem_read_d = 1'b1;
                     mem_addr_d = proc_addr[ADDR_W-1:2];
                  end
               end
            end
         end
         WRITEBACK: begin
            proc_stall = 1'b1;
            if (mem_ready) begin
               wb_done     = 1'b1;
               state_d     = ALLOCATE;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = proc_addr[ADDR_W-1:2];
            end
         end
         ALLOCATE: begin
            proc_stall = 1'b1;
            if (mem_ready) begin
               fill       = 1'b1;
               state_d    = COMPARE;
               mem_read_d = 1'b0;
            end
         end
         default: state_d = COMPARE;
      endcase
   end

   // Control state, mem outputs and per-line status bits.
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q     <= COMPARE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         victim_q    <= '0;
         midx_q      <= '0;
         for (int s = 0; s < int'(SETS); s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < int'(WAYS); w++) age_q[s][w] <= AW'(w);
         end
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         victim_q    <= victim_d;
         midx_q      <= midx_d;
         if (hit_upd) begin
            age_q[idx] <= age_nxt;
            if (is_wr) dirty_q[idx][hit_way] <= 1'b1;
         end
         if (wb_done) dirty_q[midx_q][victim_q] <= 1'b0;
         if (fill) begin
            valid_q[midx_q][victim_q] <= 1'b1;
            dirty_q[midx_q][victim_q] <= 1'b0;
         end
      end
   end

   // Line data and tags carry no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (hit_upd && is_wr) data_q[idx][hit_way][{off, 5'd0} +: WORD_W] <= proc_wdata;
      if (fill) begin
         data_q[midx_q][victim_q] <= mem_rdata;
         tag_q[midx_q][victim_q]  <= tag;
      end
   end

endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc: directed table for a 4-set/2-way cache, reset corner cases,
// and a random sweep of a 64-set/4-way cache against a word-level reference.
module tb_cache_assoc;

   logic clk, rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- DUT 1: SETS=4, WAYS=2 ----------------
   logic         p_rd1, p_wr1, stall1, m_rd1, m_wr1, m_ready1;
   logic [29:0]  p_addr1;
   logic [31:0]  p_wd1, rdata1;
   logic [27:0]  m_addr1;
   logic [127:0] m_wd1, m_rdata1;

   cache_assoc #(.SETS(4), .WAYS(2)) dut1 (
      .clk(clk), .proc_reset_n(rst_n), .proc_read(p_rd1), .proc_write(p_wr1),
      .proc_addr(p_addr1), .proc_wdata(p_wd1), .proc_rdata(rdata1), .proc_stall(stall1),
      .mem_read(m_rd1), .mem_write(m_wr1), .mem_addr(m_addr1), .mem_wdata(m_wd1),
      .mem_rdata(m_rdata1), .mem_ready(m_ready1));

   // ---------------- DUT 2: SETS=64, WAYS=4 ----------------
   logic         p_rd2, p_wr2, stall2, m_rd2, m_wr2, m_ready2;
   logic [29:0]  p_addr2;
   logic [31:0]  p_wd2, rdata2;
   logic [27:0]  m_addr2;
   logic [127:0] m_wd2, m_rdata2;

   cache_assoc #(.SETS(64), .WAYS(4)) dut2 (
      .clk(clk), .proc_reset_n(rst_n), .proc_read(p_rd2), .proc_write(p_wr2),
      .proc_addr(p_addr2), .proc_wdata(p_wd2), .proc_rdata(rdata2), .proc_stall(stall2),
      .mem_read(m_rd2), .mem_write(m_wr2), .mem_addr(m_addr2), .mem_wdata(m_wd2),
      .mem_rdata(m_rdata2), .mem_ready(m_ready2));

   // Backing memory content for never-written blocks.
   function automatic logic [31:0] line_word(input logic [27:0] blk, input int j);
      return 32'hAAAA0000 + ((32'(blk) ^ 32'h4) << 8) + 32'(j);
   endfunction

   function automatic logic [127:0] line_of(input logic [27:0] blk);
      logic [127:0] l;
      for (int j = 0; j < 4; j++) l[j*32 +: 32] = line_word(blk, j);
      return l;
   endfunction

   // Memory responders: answer after lat cycles of an active strobe.
   logic [127:0] mem1 [logic [27:0]];
   logic [127:0] mem2 [logic [27:0]];
   int lat1 = 1, lat2 = 1, cnt1 = 0, cnt2 = 0;

   always @(negedge clk) begin
      m_ready1 = 1'b0;
      if (m_rd1 || m_wr1) begin
         cnt1++;
         if (cnt1 >= lat1) begin
            m_ready1 = 1'b1;
            cnt1 = 0;
            if (m_wr1) mem1[m_addr1] = m_wd1;
            else m_rdata1 = mem1.exists(m_addr1) ? mem1[m_addr1] : line_of(m_addr1);
         end
      end else cnt1 = 0;
   end

   always @(negedge clk) begin
      m_ready2 = 1'b0;
      if (m_rd2 || m_wr2) begin
         cnt2++;
         if (cnt2 >= lat2) begin
            m_ready2 = 1'b1;
            cnt2 = 0;
            if (m_wr2) mem2[m_addr2] = m_wd2;
            else m_rdata2 = mem2.exists(m_addr2) ? mem2[m_addr2] : line_of(m_addr2);
         end
      end else cnt2 = 0;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: no completion within cycle budget", nm);
   endtask

   // Observations of one DUT1 access.
   int          o_st;
   logic [31:0] o_rdata, o_wrw;
   logic [27:0] o_rda, o_wra;
   bit          o_srd, o_swr, o_both;

   task automatic acc1(input bit rd, input bit wr, input logic [29:0] a,
                       input logic [31:0] wd, input int lat);
      bit done = 0;
      lat1 = lat; o_st = 0; o_rdata = '0; o_srd = 0; o_swr = 0; o_both = 0;
      o_rda = '0; o_wra = '0; o_wrw = '0;
      p_rd1 = rd; p_wr1 = wr; p_addr1 = a; p_wd1 = wd;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (m_rd1 && m_wr1) o_both = 1;
         if (m_rd1) begin o_srd = 1; o_rda = m_addr1; end
         if (m_wr1) begin o_swr = 1; o_wra = m_addr1; o_wrw = m_wd1[31:0]; end
         if (!stall1) begin o_rdata = rdata1; done = 1; break; end
         o_st++;
      end
      if (!done) fail_timeout("acc1_timeout");
      @(posedge clk); #1;
      p_rd1 = 0; p_wr1 = 0;
   endtask

   task automatic acc2(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                       input int lat, output logic [31:0] rd_o);
      bit done = 0;
      lat2 = lat; rd_o = '0;
      p_rd2 = !wr; p_wr2 = wr; p_addr2 = a; p_wd2 = wd;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!stall2) begin rd_o = rdata2; done = 1; break; end
      end
      if (!done) fail_timeout("acc2_timeout");
      @(posedge clk); #1;
      p_rd2 = 0; p_wr2 = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      p_rd1 = 0; p_wr1 = 0; p_rd2 = 0; p_wr2 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          rst, rd, wr;
      logic [29:0] addr;
      logic [31:0] wd;
      int          lat, stalls;
      bit          chk;
      logic [31:0] rdata;
      bit          mrd;
      logic [27:0] mrd_a;
      bit          mwr;
      logic [27:0] mwr_a;
      logic [31:0] mwr_w0;
   } vec_t;

   function automatic vec_t mk(bit rst, bit rd, bit wr, logic [29:0] addr, logic [31:0] wd,
                               int lat, int stalls, bit chk, logic [31:0] rdata,
                               bit mrd, logic [27:0] mrd_a, bit mwr, logic [27:0] mwr_a,
                               logic [31:0] mwr_w0);
      vec_t v;
      v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.lat = lat;
      v.stalls = stalls; v.chk = chk; v.rdata = rdata; v.mrd = mrd; v.mrd_a = mrd_a;
      v.mwr = mwr; v.mwr_a = mwr_a; v.mwr_w0 = mwr_w0;
      return v;
   endfunction

   vec_t tbl[$];
   logic [31:0] ref2 [logic [29:0]];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      p_rd1 = 0; p_wr1 = 0; p_addr1 = '0; p_wd1 = '0;
      p_rd2 = 0; p_wr2 = 0; p_addr2 = '0; p_wd2 = '0;
      m_ready1 = 0; m_rdata1 = '0; m_ready2 = 0; m_rdata2 = '0;

      // Cold reset state.
      do_reset();
      @(negedge clk);
      check("rst_mem_read",  64'(m_rd1), 64'd0);
      check("rst_mem_write", 64'(m_wr1), 64'd0);
      check("rst_mem_addr",  64'(m_addr1), 64'd0);
      check("rst_mem_wdata", 64'(|m_wd1), 64'd0);
      check("rst_stall",     64'(stall1), 64'd0);
      check("rst_rdata",     64'(rdata1), 64'd0);
      @(posedge clk); #1;

      //            rst rd wr addr    wdata         lat st chk rdata              mrd addr  mwr addr w0
      tbl.push_back(mk(1, 1, 0, 30'h10, 32'h0,        3, 4, 1, line_word(4, 0),   1, 28'h4, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 0, 1, 30'h11, 32'hDEADBEEF, 1, 0, 0, 32'h0,             0, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h11, 32'h0,        1, 0, 1, 32'hDEADBEEF,      0, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 1, 30'h11, 32'h0BADF00D, 1, 0, 1, 32'hDEADBEEF,      0, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h11, 32'h0,        1, 0, 1, 32'hDEADBEEF,      0, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(1, 1, 0, 30'h00, 32'h0,        1, 2, 1, line_word(0, 0),   1, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h10, 32'h0,        2, 3, 1, line_word(4, 0),   1, 28'h4, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h20, 32'h0,        1, 2, 1, line_word(8, 0),   1, 28'h8, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h00, 32'h0,        1, 2, 1, line_word(0, 0),   1, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h22, 32'h0,        1, 0, 1, line_word(8, 2),   0, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h13, 32'h0,        1, 2, 1, line_word(4, 3),   1, 28'h4, 0, 28'h0, 32'h0));
      tbl.push_back(mk(1, 0, 1, 30'h00, 32'h12345678, 1, 2, 0, 32'h0,             1, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h10, 32'h0,        1, 2, 1, line_word(4, 0),   1, 28'h4, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h21, 32'h0,        2, 5, 1, line_word(8, 1),   1, 28'h8, 1, 28'h0, 32'h12345678));
      tbl.push_back(mk(0, 1, 0, 30'h00, 32'h0,        1, 2, 1, 32'h12345678,      1, 28'h0, 0, 28'h0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 30'h01, 32'h0,        1, 0, 1, line_word(0, 1),   0, 28'h0, 0, 28'h0, 32'h0));

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         acc1(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat);
         check($sformatf("r%0d_stall_cycles", i), 64'(o_st), 64'(tbl[i].stalls));
         if (tbl[i].chk) check($sformatf("r%0d_rdata", i), 64'(o_rdata), 64'(tbl[i].rdata));
         check($sformatf("r%0d_mem_read", i), 64'(o_srd), 64'(tbl[i].mrd));
         if (tbl[i].mrd) check($sformatf("r%0d_mem_read_addr", i), 64'(o_rda), 64'(tbl[i].mrd_a));
         check($sformatf("r%0d_mem_write", i), 64'(o_swr), 64'(tbl[i].mwr));
         if (tbl[i].mwr) begin
            check($sformatf("r%0d_mem_write_addr", i), 64'(o_wra), 64'(tbl[i].mwr_a));
            check($sformatf("r%0d_mem_wdata_w0", i), 64'(o_wrw), 64'(tbl[i].mwr_w0));
         end
         check($sformatf("r%0d_strobes_exclusive", i), 64'(o_both), 64'd0);
      end

      // Async reset in the middle of ALLOCATE.
      do_reset();
      lat1 = 50;
      p_rd1 = 1; p_addr1 = 30'h40;
      @(negedge clk);
      @(negedge clk);
      check("midalloc_mem_read_high", 64'(m_rd1), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midalloc_mem_read_drop", 64'(m_rd1), 64'd0);
      check("midalloc_mem_write_low", 64'(m_wr1), 64'd0);
      p_rd1 = 0;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      acc1(1, 0, 30'h40, 32'h0, 1);
      check("post_rst_stall_cycles", 64'(o_st), 64'd2);
      check("post_rst_mem_read", 64'(o_srd), 64'd1);
      check("post_rst_mem_addr", 64'(o_rda), 64'h10);
      check("post_rst_rdata", 64'(o_rdata), 64'(line_word(28'h10, 0)));

      // Random sweep on the 64-set, 4-way configuration.
      do_reset();
      for (int k = 0; k < 200; k++) begin
         logic [29:0] a;
         logic [31:0] wd, got, exp;
         bit          wr;
         a  = 30'(($urandom_range(0, 7) << 8) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3));
         wr = ($urandom_range(0, 1) == 1);
         wd = $urandom;
         acc2(wr, a, wd, $urandom_range(1, 5), got);
         if (wr) ref2[a] = wd;
         else begin
            exp = ref2.exists(a) ? ref2[a] : line_word(a[29:2], int'(a[1:0]));
            check($sformatf("sweep%0d_rdata_%0h", k, a), 64'(got), 64'(exp));
         end
      end
      for (int s = 0; s < 2; s++) begin
         logic [3:0] seen = '0;
         for (int w = 0; w < 4; w++) seen[dut2.age_q[s][w]] = 1'b1;
         check($sformatf("sweep_age_perm_set%0d", s), 64'(seen), 64'hF);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
